dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter that shares one data-memory port between the hart's load/store path (port 0) and a second master such as a program loader or DMA engine (port 1). Replaces the direct hart-to-dmem connection once memory gains a valid/ready request channel and a variable-latency response. Accepts one transaction at a time, forwards it to memory from registers, and returns the response to the owning requester. A timeout prevents a lost response from locking up the port.

## Interface
- RR, 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- TIMEOUT, 64: cycles to wait in WAIT_RSP before returning an error response; range 1..1023.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low. Deassertion is synchronized externally.
- i_reqN_valid  in  1  request from port N (N = 0,1).
- o_reqN_ready  out  1  request accepted this cycle.
- i_reqN_addr  in  32  word-aligned address.
- i_reqN_wen  in  1  1 = write, 0 = read.
- i_reqN_wdata  in  32  write data, pre-shifted into byte lanes.
- i_reqN_mask  in  4  byte-lane mask.
- o_reqN_rvalid  out  1  response for port N; one-cycle pulse.
- o_reqN_rdata  out  32  read data; 0 for writes and errors.
- o_reqN_err  out  1  response is a timeout error; valid with rvalid.
- o_mem_valid, o_mem_addr[31:0], o_mem_wen, o_mem_wdata[31:0], o_mem_mask[3:0]  out  request channel to memory.
- i_mem_ready  in  1  memory accepts the request.
- i_mem_rvalid  in  1  memory response; also asserted as a write acknowledgement.
- i_mem_rdata  in  32  memory read data.

## Operation
- States: IDLE, REQ, WAIT_RSP, RESP.
- IDLE: if any i_reqN_valid, select a winner and assert its o_reqN_ready combinationally, in the same cycle. Latch addr, wen, wdata, mask and the owner index; go to REQ. The loser's ready stays 0.
- Round-robin rule (RR=1): a 1-bit last-grant register is updated on each accept. On a tie, the port not granted last wins. Reset value of last-grant = 1, so port 0 wins the first tie.
- REQ: o_mem_valid=1 with the latched fields held stable. On i_mem_ready, go to WAIT_RSP and clear the timeout counter.
- WAIT_RSP: on i_mem_rvalid, capture i_mem_rdata (or 0 if wen) and set err=0; go to RESP.
  - Otherwise the counter increments each cycle.
  - When counter == TIMEOUT-1 with no rvalid, set rdata=0, err=1, and go to RESP.
- RESP: assert owner's o_reqN_rvalid, rdata and err for exactly one cycle; go to IDLE.
- New requests are never accepted in RESP.
- i_mem_rvalid is ignored outside WAIT_RSP, including a late response after a timeout and rvalid in the same cycle as the ready handshake.
- Requesters may drop valid at any time before ready. No request state is kept until acceptance.
- Reset mid-transaction aborts it. No response is issued and the in-flight memory access is abandoned.

## Timing
- Reset values:
  - state = IDLE.
  - All o_reqN_ready, o_reqN_rvalid, o_reqN_err and o_mem_valid = 0.
  - All o_reqN_rdata, o_mem_addr, o_mem_wdata, o_mem_mask and o_mem_wen = 0.
  - Timeout counter = 0; last-grant = 1.
- Minimum latency is 3 cycles from the accept edge to the rvalid cycle, given ready at T+1 and rvalid at T+2.
  - Accept at cycle T, o_mem_valid at T+1, memory ready at T+1, rvalid at T+2, o_reqN_rvalid at T+3.
- Throughput: at most one transaction per 4 cycles.
- o_mem_* outputs, o_reqN_rvalid, o_reqN_rdata and o_reqN_err are all registered. Only o_reqN_ready is combinational, from i_reqN_valid, state and last-grant.
- The counter is $clog2(TIMEOUT+1) bits wide and saturates. The error response appears TIMEOUT cycles after entering WAIT_RSP, plus one cycle for RESP.

## Structure
- Shared package `dmem_arb_pkg`: state enum (IDLE, REQ, WAIT_RSP, RESP), port index constants PORT_HART=0 and PORT_EXT=1, and the request struct (addr, wen, wdata, mask).
- One sub-module, `rr_pick`: combinational 2-way picker with inputs valid[1:0], last-grant and RR, and output one-hot grant.
- Timeout counter and FSM live in the top module.

## Test plan
- Single read, port 0 at addr 0x100, memory ready in 1 cycle, rdata 0xDEADBEEF → o_req0_rvalid exactly 3 cycles after accept, rdata 0xDEADBEEF, err 0; port 1 outputs stay 0.
- Both ports valid in the same cycle, 4 back-to-back transactions, RR=1 → grant order 0,1,0,1. With RR=0 → port 0 gets all four while it stays valid.
- Write, port 1 at addr 0x200, mask 0b1100, wdata 0x12340000, memory holds ready low for 5 cycles → o_mem_* stable for all 5 cycles; on ack, rvalid=1, rdata=0, err=0.
- No rvalid, TIMEOUT=8 → o_req0_rvalid with err=1 and rdata=0, TIMEOUT+1 cycles after ready. A later stray i_mem_rvalid is ignored, and the next request completes normally.
- i_rst_n pulsed low during WAIT_RSP → all outputs 0 immediately (asynchronously). After release, no response is issued for the aborted request, and port 0 wins a tie.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic PORT_HART = 1'b0;
  localparam logic PORT_EXT  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rtl/dmem_arbiter_rr_pick.sv - combinational two-way request picker
module rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       rr,
  output logic [1:0] grant
);

  // On a tie, round-robin favours the port not granted last; fixed mode always favours the hart
  always_comb begin
    grant = 2'b00;
    if (valid[PORT_HART] && valid[PORT_EXT]) begin
      if (rr && (last_grant == PORT_HART)) grant[PORT_EXT] = 1'b1;
      else                                 grant[PORT_HART] = 1'b1;
    end else if (valid[PORT_HART]) begin
      grant[PORT_HART] = 1'b1;
    end else if (valid[PORT_EXT]) begin
      grant[PORT_EXT] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with response timeout
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter bit RR      = 1'b1,
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_addr,
  input  logic        i_req0_wen,
  input  logic [31:0] i_req0_wdata,
  input  logic [3:0]  i_req0_mask,
  output logic        o_req0_rvalid,
  output logic [31:0] o_req0_rdata,
  output logic        o_req0_err,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_addr,
  input  logic        i_req1_wen,
  input  logic [31:0] i_req1_wdata,
  input  logic [3:0]  i_req1_mask,
  output logic        o_req1_rvalid,
  output logic [31:0] o_req1_rdata,
  output logic        o_req1_err,
  output logic        o_mem_valid,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

  state_t        state_q, state_d;
  mem_req_t      req_q, req_in;
  logic          owner_q, last_q, mem_valid_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    grant;
  logic          accept, rsp_hit, rsp_timeout, done;
  logic [1:0]    rvalid_q, err_q;
  logic [31:0]   rdata0_q, rdata1_q, rdata_rsp;

  rr_pick u_pick (
    .valid      ({i_req1_valid, i_req0_valid}),
    .last_grant (last_q),
    .rr         (RR),
    .grant      (grant)
  );

  assign req_in = grant[PORT_EXT]
                ? '{addr: i_req1_addr, wen: i_req1_wen, wdata: i_req1_wdata, mask: i_req1_mask}
                : '{addr: i_req0_addr, wen: i_req0_wen, wdata: i_req0_wdata, mask: i_req0_mask};

  // Next-state logic: accept only from IDLE, give up on the response after TIMEOUT cycles
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    rsp_hit     = 1'b0;
    rsp_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_mem_ready) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (i_mem_rvalid) begin
          rsp_hit = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_timeout = 1'b1;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done         = rsp_hit | rsp_timeout;
  assign rdata_rsp    = (rsp_hit && !req_q.wen) ? i_mem_rdata : 32'h0;
  assign o_req0_ready = accept & grant[PORT_HART];
  assign o_req1_ready = accept & grant[PORT_EXT];

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Request latch, owner/last-grant tracking and the saturating response timer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q       <= '0;
      owner_q     <= PORT_HART;
      last_q      <= PORT_EXT;
      mem_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else if (accept) begin
      req_q       <= req_in;
      owner_q     <= grant[PORT_EXT];
      last_q      <= grant[PORT_EXT];
      mem_valid_q <= 1'b1;
    end else if (state_q == REQ && i_mem_ready) begin
      mem_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else if (state_q == WAIT_RSP && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // One-cycle response to the owning port; data and error are zero whenever rvalid is low
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      rvalid_q <= {done && (owner_q == PORT_EXT), done && (owner_q == PORT_HART)};
      err_q    <= {rsp_timeout && (owner_q == PORT_EXT), rsp_timeout && (owner_q == PORT_HART)};
      rdata0_q <= (done && (owner_q == PORT_HART)) ? rdata_rsp : 32'h0;
      rdata1_q <= (done && (owner_q == PORT_EXT))  ? rdata_rsp : 32'h0;
    end
  end

  assign o_mem_valid   = mem_valid_q;
  assign o_mem_addr    = req_q.addr;
  assign o_mem_wen     = req_q.wen;
  assign o_mem_wdata   = req_q.wdata;
  assign o_mem_mask    = req_q.mask;
  assign o_req0_rvalid = rvalid_q[0];
  assign o_req1_rvalid = rvalid_q[1];
  assign o_req0_err    = err_q[0];
  assign o_req1_err    = err_q[1];
  assign o_req0_rdata  = rdata0_q;
  assign o_req1_rdata  = rdata1_q;

endmodule
